// File: rtl/button_cmd_scheduler.sv
// rtl/button_cmd_scheduler.sv - debounced button levels to press/auto-repeat commands
// Commands are queued in a first-word fall-through FIFO and drained over valid/ready.
module button_cmd_scheduler #(
   parameter int FCLK       = 20000000,
   parameter int HOLD_MS    = 500,
   parameter int REPEAT_MS  = 100,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          i_clk_mhz,
   input  logic                          i_rst_mhz,
   input  logic [3:0]                    i_btns_deb,
   input  logic                          i_enable,
   output logic                          o_cmd_valid,
   output logic [1:0]                    o_cmd_code,
   output logic                          o_cmd_repeat,
   input  logic                          i_cmd_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
   output logic                          o_overflow,
   input  logic                          i_clr_overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [31:0] c_hold = 32'(64'(FCLK) * 64'(HOLD_MS) / 64'd1000);
   localparam logic [31:0] c_rpt  = 32'(64'(FCLK) * 64'(REPEAT_MS) / 64'd1000);
   localparam logic [AW:0] c_full = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HELD = 2'd1,
      ST_RPT  = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [3:0]  prev, latched, latched_nxt;
   logic        prev_valid;
   logic [31:0] timer, timer_nxt;
   logic        push, push_rpt, press, one_hot;
   logic [1:0]  push_idx;

   logic [2:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          pop, full, wr_en;

   function automatic logic [1:0] btn_idx(input logic [3:0] b);
      case (b)
         4'b0010: btn_idx = 2'd1;
         4'b0100: btn_idx = 2'd2;
         4'b1000: btn_idx = 2'd3;
         default: btn_idx = 2'd0;
      endcase
   endfunction

   // prev_valid keeps a button held through reset release from looking like a fresh press
   assign one_hot = (i_btns_deb != 4'b0000) && ((i_btns_deb & (i_btns_deb - 4'd1)) == 4'b0000);
   assign press   = prev_valid && (prev == 4'b0000) && one_hot;

   always_ff @(posedge i_clk_mhz or posedge i_rst_mhz) begin
      if (i_rst_mhz) begin
         state      <= ST_IDLE;
         prev       <= 4'b0000;
         prev_valid <= 1'b0;
         latched    <= 4'b0000;
         timer      <= 32'd0;
      end else begin
         state      <= state_nxt;
         prev       <= i_btns_deb;
         prev_valid <= 1'b1;
         latched    <= latched_nxt;
         timer      <= timer_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      latched_nxt = latched;
      timer_nxt   = 32'd0;
      push        = 1'b0;
      push_rpt    = 1'b0;
      push_idx    = btn_idx(latched);
      case (state)
         ST_IDLE: begin
            if (press && i_enable) begin
               push        = 1'b1;
               push_idx    = btn_idx(i_btns_deb);
               latched_nxt = i_btns_deb;
               state_nxt   = ST_HELD;
            end
         end
         ST_HELD: begin
            if ((i_btns_deb != latched) || !i_enable) begin
               state_nxt = ST_IDLE;
            end else if (timer == c_hold - 32'd1) begin
               push      = 1'b1;
               push_rpt  = 1'b1;
               state_nxt = ST_RPT;
            end else begin
               timer_nxt = timer + 32'd1;
            end
         end
         ST_RPT: begin
            if ((i_btns_deb != latched) || !i_enable) begin
               state_nxt = ST_IDLE;
            end else if (timer == c_rpt - 32'd1) begin
               push     = 1'b1;
               push_rpt = 1'b1;
            end else begin
               timer_nxt = timer + 32'd1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // A push into a full FIFO still lands when the head is popped in the same cycle
   assign o_cmd_valid = (count != '0);
   assign pop         = o_cmd_valid && i_cmd_ready;
   assign full        = (count == c_full);
   assign wr_en       = push && (!full || pop);

   always_ff @(posedge i_clk_mhz or posedge i_rst_mhz) begin
      if (i_rst_mhz) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_overflow <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 3'b000;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= {push_rpt, push_idx};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && !pop)      count <= count + 1'b1;
         else if (!wr_en && pop) count <= count - 1'b1;
         if (push && full && !pop) o_overflow <= 1'b1;
         else if (i_clr_overflow)  o_overflow <= 1'b0;
      end
   end

   assign o_cmd_code   = o_cmd_valid ? mem[rd_ptr][1:0] : 2'b00;
   assign o_cmd_repeat = o_cmd_valid ? mem[rd_ptr][2]   : 1'b0;
   assign o_fifo_count = count;

endmodule

// File: tb/tb_button_cmd_scheduler.sv
// tb/tb_button_cmd_scheduler.sv - directed bench for button_cmd_scheduler
module tb_button_cmd_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] btns = 4'b0000;
   logic       enable = 1'b1;
   logic       valid, rpt, ready = 1'b0, ovf, clr = 1'b0;
   logic [1:0] code;
   logic [2:0] cnt;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   int base;
   int log_cyc[$];
   logic [1:0] log_code[$];
   logic log_rpt[$];

   button_cmd_scheduler #(.FCLK(1000), .HOLD_MS(5), .REPEAT_MS(2), .FIFO_DEPTH(4)) dut (
      .i_clk_mhz(clk), .i_rst_mhz(rst), .i_btns_deb(btns), .i_enable(enable),
      .o_cmd_valid(valid), .o_cmd_code(code), .o_cmd_repeat(rpt), .i_cmd_ready(ready),
      .o_fifo_count(cnt), .o_overflow(ovf), .i_clr_overflow(clr));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // records every accepted command 1 ns before the edge that pops it
   always @(negedge clk) begin
      #4;
      if (valid === 1'b1 && ready === 1'b1) begin
         log_cyc.push_back(cyc);
         log_code.push_back(code);
         log_rpt.push_back(rpt);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_log();
      log_cyc.delete();
      log_code.delete();
      log_rpt.delete();
   endtask

   task automatic test_reset();
      tick(2);
      n_total++; if (valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid); else n_pass++;
      n_total++; if (cnt !== 3'd0) $display("FAIL rst_count: got %0d want 0", cnt); else n_pass++;
      n_total++; if (ovf !== 1'b0) $display("FAIL rst_overflow: got %b want 0", ovf); else n_pass++;
      n_total++; if (code !== 2'd0) $display("FAIL rst_code: got %0d want 0", code); else n_pass++;
      n_total++; if (rpt !== 1'b0) $display("FAIL rst_repeat: got %b want 0", rpt); else n_pass++;
      rst = 1'b0;
      tick(3);
   endtask

   task automatic test_single_press();
      ready = 1'b1;
      clear_log();
      btns = 4'b0100;
      base = cyc;
      tick(1);
      n_total++; if (valid !== 1'b1) $display("FAIL t1_valid_latency: got %b want 1", valid); else n_pass++;
      n_total++; if (code !== 2'd2) $display("FAIL t1_code: got %0d want 2", code); else n_pass++;
      tick(2);
      btns = 4'b0000;
      tick(6);
      n_total++;
      if (log_cyc.size() !== 1) $display("FAIL t1_cmd_count: got %0d want 1", log_cyc.size());
      else if (log_cyc[0] - base !== 1 || log_code[0] !== 2'd2 || log_rpt[0] !== 1'b0)
         $display("FAIL t1_cmd: got off=%0d code=%0d rpt=%b want off=1 code=2 rpt=0",
                  log_cyc[0] - base, log_code[0], log_rpt[0]);
      else n_pass++;
   endtask

   task automatic test_hold_repeat();
      int exp_off[5] = '{1, 6, 8, 10, 12};
      logic exp_rpt[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      ready = 1'b1;
      clear_log();
      btns = 4'b0001;
      base = cyc;
      tick(12);
      btns = 4'b0000;
      tick(8);
      n_total++;
      if (log_cyc.size() !== 5) $display("FAIL t2_cmd_count: got %0d want 5", log_cyc.size());
      else begin
         n_pass++;
         for (int i = 0; i < 5; i++) begin
            n_total++;
            if (log_cyc[i] - base !== exp_off[i] || log_code[i] !== 2'd0 || log_rpt[i] !== exp_rpt[i])
               $display("FAIL t2_cmd%0d: got off=%0d code=%0d rpt=%b want off=%0d code=0 rpt=%b",
                        i, log_cyc[i] - base, log_code[i], log_rpt[i], exp_off[i], exp_rpt[i]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_overflow();
      logic [3:0] seq[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      ready = 1'b0;
      clear_log();
      for (int i = 0; i < 5; i++) begin
         btns = seq[i];
         tick(1);
         btns = 4'b0000;
         tick(1);
      end
      tick(1);
      n_total++; if (cnt !== 3'd4) $display("FAIL t3_count_full: got %0d want 4", cnt); else n_pass++;
      n_total++; if (ovf !== 1'b1) $display("FAIL t3_overflow_set: got %b want 1", ovf); else n_pass++;
      ready = 1'b1;
      tick(4);
      ready = 1'b0;
      tick(1);
      n_total++;
      if (log_cyc.size() !== 4) $display("FAIL t3_drain_count: got %0d want 4", log_cyc.size());
      else begin
         n_pass++;
         for (int i = 0; i < 4; i++) begin
            n_total++;
            if (log_code[i] !== 2'(i) || log_rpt[i] !== 1'b0)
               $display("FAIL t3_order%0d: got code=%0d rpt=%b want code=%0d rpt=0",
                        i, log_code[i], log_rpt[i], i);
            else n_pass++;
         end
      end
      n_total++; if (cnt !== 3'd0) $display("FAIL t3_count_empty: got %0d want 0", cnt); else n_pass++;
      n_total++; if (ovf !== 1'b1) $display("FAIL t3_overflow_sticky: got %b want 1", ovf); else n_pass++;
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      n_total++; if (ovf !== 1'b0) $display("FAIL t3_overflow_clear: got %b want 0", ovf); else n_pass++;
   endtask

   task automatic test_no_press();
      ready = 1'b0;
      btns = 4'b0011; tick(3);
      btns = 4'b0001; tick(2);
      btns = 4'b0010; tick(2);
      btns = 4'b0000; tick(2);
      enable = 1'b0;
      btns = 4'b0100; tick(2);
      btns = 4'b0000; tick(2);
      enable = 1'b1;
      tick(1);
      n_total++; if (cnt !== 3'd0) $display("FAIL t4_count: got %0d want 0", cnt); else n_pass++;
      n_total++; if (valid !== 1'b0) $display("FAIL t4_valid: got %b want 0", valid); else n_pass++;
   endtask

   task automatic test_full_push_pop();
      logic [1:0] exp_code[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
      logic exp_rpt[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      ready = 1'b0;
      clear_log();
      btns = 4'b0001; tick(1); btns = 4'b0000; tick(1);
      btns = 4'b0010; tick(1); btns = 4'b0000; tick(1);
      btns = 4'b0100; tick(1); btns = 4'b0000; tick(1);
      btns = 4'b1000;
      tick(5);
      n_total++; if (cnt !== 3'd4) $display("FAIL t5_count_before: got %0d want 4", cnt); else n_pass++;
      ready = 1'b1;
      tick(1);
      n_total++; if (cnt !== 3'd4) $display("FAIL t5_count_pushpop: got %0d want 4", cnt); else n_pass++;
      n_total++; if (ovf !== 1'b0) $display("FAIL t5_overflow: got %b want 0", ovf); else n_pass++;
      ready = 1'b0;
      btns = 4'b0000;
      tick(2);
      ready = 1'b1;
      tick(4);
      ready = 1'b0;
      tick(1);
      n_total++;
      if (log_cyc.size() !== 5) $display("FAIL t5_drain_count: got %0d want 5", log_cyc.size());
      else begin
         n_pass++;
         for (int i = 0; i < 5; i++) begin
            n_total++;
            if (log_code[i] !== exp_code[i] || log_rpt[i] !== exp_rpt[i])
               $display("FAIL t5_order%0d: got code=%0d rpt=%b want code=%0d rpt=%b",
                        i, log_code[i], log_rpt[i], exp_code[i], exp_rpt[i]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_mid_rpt();
      ready = 1'b0;
      clear_log();
      btns = 4'b0001;
      tick(7);
      n_total++; if (cnt !== 3'd2) $display("FAIL t6_count_pre: got %0d want 2", cnt); else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_total++; if (valid !== 1'b0) $display("FAIL t6_async_valid: got %b want 0", valid); else n_pass++;
      n_total++; if (cnt !== 3'd0) $display("FAIL t6_async_count: got %0d want 0", cnt); else n_pass++;
      tick(1);
      rst = 1'b0;
      ready = 1'b1;
      tick(10);
      n_total++; if (log_cyc.size() !== 0) $display("FAIL t6_held_after_rst: got %0d cmds want 0", log_cyc.size()); else n_pass++;
      btns = 4'b0000; tick(2);
      btns = 4'b0010; tick(2);
      btns = 4'b0000; tick(3);
      n_total++;
      if (log_cyc.size() !== 1) $display("FAIL t6_new_press_count: got %0d want 1", log_cyc.size());
      else if (log_code[0] !== 2'd1 || log_rpt[0] !== 1'b0)
         $display("FAIL t6_new_press: got code=%0d rpt=%b want code=1 rpt=0", log_code[0], log_rpt[0]);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_hold_repeat();
      test_overflow();
      test_no_press();
      test_full_push_pop();
      test_reset_mid_rpt();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
